// File: rtl/condlogic_nbit_if.sv
// Handshake and data bundle between the ALU, the conditional-execution
// stage and the writeback/memory consumer.
interface condlogic_nbit_if #(
  parameter int Nbits = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [Nbits-1:0] Result;
  logic [3:0]       ALUFlags;
  logic [3:0]       Cond;
  logic [1:0]       FlagW;
  logic             RegW;
  logic             MemW;
  logic             PCS;
  logic             out_valid;
  logic             out_ready;
  logic [Nbits-1:0] out_result;
  logic             RegWrite;
  logic             MemWrite;
  logic             PCSrc;
  logic             CondEx_q;
  logic [3:0]       Flags;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, Result, ALUFlags, Cond, FlagW, RegW, MemW, PCS, out_ready,
    input  in_ready, out_valid, out_result, RegWrite, MemWrite, PCSrc,
           CondEx_q, Flags
  );

  // Conditional-execution stage side.
  modport slave (
    input  in_valid, Result, ALUFlags, Cond, FlagW, RegW, MemW, PCS, out_ready,
    output in_ready, out_valid, out_result, RegWrite, MemWrite, PCSrc,
           CondEx_q, Flags
  );
endinterface

// File: rtl/condlogic_nbit.sv
// Conditional-execution stage: holds the architectural {N,Z,C,V} flags,
// evaluates the condition field against them, and registers the result
// with gated write strobes into a single-entry output buffer.
module condlogic_nbit #(
  parameter int Nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  condlogic_nbit_if.slave  bus
);

  typedef enum logic {
    EMPTY,
    FULL
  } buf_state_t;

  buf_state_t       state;
  logic [3:0]       flags_q;
  logic [Nbits-1:0] result_q;
  logic             regwrite_q;
  logic             memwrite_q;
  logic             pcsrc_q;
  logic             condex_q;

  logic             acc;
  logic             condex;
  logic             n, z, c, v;

  assign {n, z, c, v} = flags_q;

  assign bus.out_valid  = (state == FULL);
  assign bus.in_ready   = (state == EMPTY) | bus.out_ready;
  assign acc            = bus.in_valid & bus.in_ready;

  assign bus.Flags      = flags_q;
  assign bus.out_result = result_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.MemWrite   = memwrite_q;
  assign bus.PCSrc      = pcsrc_q;
  assign bus.CondEx_q   = condex_q;

  // Condition outcome from the flags as they stand before this transaction.
  always_comb begin
    condex = 1'b0;
    unique case (bus.Cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      4'b1111: condex = 1'b0;
      default: condex = 1'b0;
    endcase
  end

  // Output buffer FSM, registered outputs and architectural flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      flags_q    <= '0;
      result_q   <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      pcsrc_q    <= 1'b0;
      condex_q   <= 1'b0;
    end else if (acc) begin
      state      <= FULL;
      result_q   <= bus.Result;
      regwrite_q <= bus.RegW & condex;
      memwrite_q <= bus.MemW & condex;
      pcsrc_q    <= bus.PCS & condex;
      condex_q   <= condex;
      if (condex) begin
        if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
      end
    end else if (bus.out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_condlogic_nbit.sv
// Bench for condlogic_nbit: directed scenarios with literal expectations,
// then randomized traffic, all checked against a behavioural model.
module tb_condlogic_nbit;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  condlogic_nbit_if #(.Nbits(NB)) bus ();

  condlogic_nbit #(.Nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit          m_full;
  bit [3:0]    m_flags;
  bit [NB-1:0] m_res;
  bit          m_rw, m_mw, m_pcs, m_cx;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition predicate: odd codes are the negation of the even code below.
  function automatic bit cond_ok(input bit [3:0] cc, input bit [3:0] f);
    bit n, z, c, v, base;
    {n, z, c, v} = f;
    if (cc == 4'd14) return 1'b1;
    if (cc == 4'd15) return 1'b0;
    case (cc >> 1)
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return cc[0] ? !base : base;
  endfunction

  always @(posedge clk) begin
    bit rdy, a, cx;
    if (reset) begin
      m_full = 0; m_flags = '0; m_res = '0;
      m_rw = 0; m_mw = 0; m_pcs = 0; m_cx = 0;
    end else begin
      rdy = !m_full || bus.out_ready;
      a   = bus.in_valid && rdy;
      if (a) begin
        cx     = cond_ok(bus.Cond, bus.ALUFlags === 4'bx ? 4'b0 : m_flags);
        cx     = cond_ok(bus.Cond, m_flags);
        m_full = 1;
        m_res  = bus.Result;
        m_rw   = bus.RegW && cx;
        m_mw   = bus.MemW && cx;
        m_pcs  = bus.PCS && cx;
        m_cx   = cx;
        if (cx)
          m_flags = (bus.FlagW[1] ? (bus.ALUFlags & 4'hC) : (m_flags & 4'hC)) |
                    (bus.FlagW[0] ? (bus.ALUFlags & 4'h3) : (m_flags & 4'h3));
      end else if (bus.out_ready) begin
        m_full = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_out_valid", bus.out_valid, m_full);
      cmp("m_in_ready",  bus.in_ready, !m_full || bus.out_ready);
      cmp("m_flags",     bus.Flags, m_flags);
      cmp("m_result",    bus.out_result, m_res);
      cmp("m_regwrite",  bus.RegWrite, m_rw);
      cmp("m_memwrite",  bus.MemWrite, m_mw);
      cmp("m_pcsrc",     bus.PCSrc, m_pcs);
      cmp("m_condex",    bus.CondEx_q, m_cx);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit [NB-1:0] res, input bit [3:0] af,
                       input bit [3:0] cc, input bit [1:0] fw,
                       input bit rw, input bit mw, input bit pcs);
    bus.in_valid = 1'b1;
    bus.Result   = res;
    bus.ALUFlags = af;
    bus.Cond     = cc;
    bus.FlagW    = fw;
    bus.RegW     = rw;
    bus.MemW     = mw;
    bus.PCS      = pcs;
  endtask

  initial begin
    bit hold;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    drive(8'hA5, 4'hF, 4'hE, 2'b11, 1, 1, 1);

    // Reset held two cycles with in_valid asserted
    tick; chk_en = 1'b1;
    tick;
    cmp("rst_flags", bus.Flags, 4'b0000);
    cmp("rst_out_valid", bus.out_valid, 0);
    cmp("rst_strobes", {bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.CondEx_q}, 0);
    cmp("rst_result", bus.out_result, 0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b0;
    tick;
    cmp("rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;

    // Flag write then EQ / NE back-to-back
    drive(8'h00, 4'b0100, 4'b1110, 2'b11, 1, 0, 0); tick;
    cmp("fw_regwrite", bus.RegWrite, 1);
    cmp("fw_flags", bus.Flags, 4'b0100);
    drive(8'h11, 4'b0000, 4'b0000, 2'b00, 1, 0, 0); tick;
    cmp("eq_regwrite", bus.RegWrite, 1);
    drive(8'h22, 4'b0000, 4'b0001, 2'b00, 1, 0, 0); tick;
    cmp("ne_regwrite", bus.RegWrite, 0);
    cmp("ne_condex", bus.CondEx_q, 0);
    cmp("ne_result", bus.out_result, 8'h22);

    // Partial flag updates
    drive(8'h01, 4'b1001, 4'b1110, 2'b11, 0, 0, 0); tick;
    cmp("pu_set", bus.Flags, 4'b1001);
    drive(8'h02, 4'b0110, 4'b1110, 2'b10, 0, 0, 0); tick;
    cmp("pu_nz", bus.Flags, 4'b0101);
    drive(8'h03, 4'b1010, 4'b1110, 2'b01, 0, 0, 0); tick;
    cmp("pu_cv", bus.Flags, 4'b0110);

    // Signed compares with N=1, V=0, Z=0
    drive(8'h04, 4'b1000, 4'b1110, 2'b11, 0, 0, 0); tick;
    cmp("sc_flags", bus.Flags, 4'b1000);
    drive(8'h05, 4'b0000, 4'b1011, 2'b00, 0, 1, 0); tick;
    cmp("lt_memwrite", bus.MemWrite, 1);
    drive(8'h06, 4'b0000, 4'b1100, 2'b00, 0, 1, 0); tick;
    cmp("gt_memwrite", bus.MemWrite, 0);
    drive(8'h07, 4'b0101, 4'b1111, 2'b11, 1, 1, 1); tick;
    cmp("nv_flags", bus.Flags, 4'b1000);
    cmp("nv_strobes", {bus.RegWrite, bus.MemWrite, bus.PCSrc}, 0);
    cmp("nv_out_valid", bus.out_valid, 1);

    // Backpressure
    bus.in_valid = 1'b0; tick;
    bus.out_ready = 1'b0;
    drive(8'hA1, 4'b0100, 4'b1110, 2'b11, 1, 0, 0); tick;
    cmp("bp_first", bus.out_result, 8'hA1);
    cmp("bp_first_flags", bus.Flags, 4'b0100);
    drive(8'hB2, 4'b0010, 4'b1110, 2'b11, 1, 0, 0); #1;
    cmp("bp_in_ready_low", bus.in_ready, 0);
    tick;
    cmp("bp_hold_result", bus.out_result, 8'hA1);
    cmp("bp_hold_flags", bus.Flags, 4'b0100);
    bus.out_ready = 1'b1; #1;
    cmp("bp_in_ready_high", bus.in_ready, 1);
    tick;
    cmp("bp_second", bus.out_result, 8'hB2);
    cmp("bp_second_flags", bus.Flags, 4'b0010);
    cmp("bp_second_valid", bus.out_valid, 1);

    // Reset during a stall
    bus.out_ready = 1'b0;
    drive(8'hC3, 4'b1111, 4'b0010, 2'b11, 1, 0, 0); tick;
    reset = 1'b1; tick;
    cmp("rs_out_valid", bus.out_valid, 0);
    cmp("rs_flags", bus.Flags, 4'b0000);
    reset = 1'b0; tick;
    cmp("rs_result", bus.out_result, 8'hC3);
    cmp("rs_condex", bus.CondEx_q, 0);
    cmp("rs_regwrite", bus.RegWrite, 0);
    cmp("rs_flags_after", bus.Flags, 4'b0000);

    // Randomized traffic, holding a stalled transaction stable
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!hold)
        drive(NB'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      if (!hold) bus.in_valid = ($urandom_range(0, 3) != 0);
      #1;
      hold = bus.in_valid && !(bus.in_ready && !reset);
      tick;
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/condlogic_nbit.md
# condlogic_nbit

Conditional-execution stage that sits directly downstream of the N-bit ALU. It consumes the ALU `Result` and its 4-bit `{N,Z,C,V}` flag vector and holds the architectural condition flags. It evaluates the instruction's 4-bit condition field against those flags, then registers the result together with gated write strobes (`RegWrite`, `MemWrite`, `PCSrc`) for writeback/memory. Transfer in and out uses a valid/ready handshake through a single-entry output buffer.

## Interface
- `Nbits`, default 8: datapath width; must match the upstream ALU.

- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream presents a transaction.
- `in_ready` out 1: stage accepts a transaction this cycle.
- `Result` in Nbits: ALU result.
- `ALUFlags` in 4: ALU flags, `{N,Z,C,V}` (bit 3 = N, bit 0 = V).
- `Cond` in 4: condition field.
- `FlagW` in 2: bit 1 enables N,Z update; bit 0 enables C,V update.
- `RegW` in 1: ungated register-write request.
- `MemW` in 1: ungated memory-write request.
- `PCS` in 1: ungated PC-write request.
- `out_valid` out 1: output register holds a transaction.
- `out_ready` in 1: downstream consumes the output this cycle.
- `out_result` out Nbits: registered `Result`.
- `RegWrite` out 1: registered `RegW & CondEx`.
- `MemWrite` out 1: registered `MemW & CondEx`.
- `PCSrc` out 1: registered `PCS & CondEx`.
- `CondEx_q` out 1: registered condition outcome.
- `Flags` out 4: current architectural flags `{N,Z,C,V}`.

## Operation
- Accept: `acc = in_valid & in_ready`.
- Output buffer FSM states:
  - EMPTY (`out_valid=0`): on `acc` go to FULL.
  - FULL (`out_valid=1`): on `out_ready & ~acc` go to EMPTY; on `out_ready & acc` stay FULL with the new data; on `~out_ready` hold all output registers unchanged.
- `in_ready = ~out_valid | out_ready` (combinational, no skid entry).
- `CondEx` is combinational from `Cond` and the current `Flags` register, i.e. the flags as they stand before this transaction updates them.
- Condition codes, with N,Z,C,V from `Flags`:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never executes; no strobes, no flag update)
- Flag update on `acc & CondEx`:
  - `FlagW[1]` loads `Flags[3:2]` from `ALUFlags[3:2]`.
  - `FlagW[0]` loads `Flags[1:0]` from `ALUFlags[1:0]`.
  - Each half is updated independently.
- Condition failed (`CondEx=0`):
  - flags unchanged;
  - the transaction is still registered and emitted, with `RegWrite=MemWrite=PCSrc=0` and `CondEx_q=0`;
  - `out_result` still carries `Result`.
- Flags never change without `acc`.

## Timing
- Latency: 1 cycle. A transaction accepted on edge k appears on the outputs with `out_valid=1` after edge k.
- Flags written at edge k are visible on `Flags`, and used for `CondEx`, from cycle k+1. A back-to-back dependent transaction therefore sees the updated flags with no bubble.
- Throughput: 1 transaction per cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `Flags=4'b0000`, `out_result=0`, `RegWrite=MemWrite=PCSrc=CondEx_q=0`. `in_ready` reads 1 in the cycle after reset.
- Reset asserted mid-operation: the buffered transaction is discarded, no flag update occurs that cycle, and reset has priority over `acc`.
- `in_valid` with `in_ready=0`: no state change. Upstream must hold its inputs stable.
- Stall (`out_valid & ~out_ready`): all outputs and `Flags` are held.

## Test plan
- **Reset:** assert `reset` 2 cycles with `in_valid=1` -> `Flags=0000`, `out_valid=0`, all strobes 0; first cycle after release `in_ready=1`.
- **Flag write plus EQ:**
  - Send `Result=8'h00`, `ALUFlags=0100`, `FlagW=11`, `Cond=1110`, `RegW=1` -> next cycle `RegWrite=1`, `Flags=0100`.
  - Then send `Cond=0000`, `RegW=1` back-to-back -> `RegWrite=1`.
  - Then `Cond=0001` -> `RegWrite=0`, `CondEx_q=0`.
- **Partial update:** with `Flags=1001`, send `ALUFlags=0110`, `FlagW=10`, `Cond=1110` -> `Flags=0101`. Then `FlagW=01`, `ALUFlags=1010`, `Cond=1110` -> `Flags=0110`.
- **Signed compare:** with `Flags` N=1, V=0, Z=0:
  - `Cond=1011` (LT) with `MemW=1` -> `MemWrite=1`.
  - `Cond=1100` (GT) -> `MemWrite=0`.
  - `Cond=1111`, `FlagW=11` -> no flag change, no strobes.
- **Backpressure:**
  - Hold `out_ready=0` while sending 2 transactions -> second stalls (`in_ready=0`), `out_result` holds the first value, `Flags` reflect only the first.
  - Raise `out_ready` -> second accepted in the same cycle the first is consumed, and it appears on the next edge.
- **Reset mid-stall:** `out_valid=1`, `out_ready=0`, pulse `reset` -> `out_valid=0`, `Flags=0000`; held upstream transaction is accepted afterwards using the reset flags.
